// File: rtl/mips_fetch_unit.sv
// Instruction-fetch initiator: issues 4-word burst reads, buffers them in a prefetch FIFO, hands {insn, pc} to decode.
// Optional macro MIPS_FETCH_PC_CHECK_EN enables the sticky fetch_err check of mem_pc against the expected beat address.
module mips_fetch_unit #(
  parameter logic [31:0] START_ADDR = 32'h8002_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [2:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic        mem_busy,
  input  logic [31:0] mem_dout,
  input  logic [31:0] mem_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ISSUE_LIMIT = CW'(FIFO_DEPTH - 4);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECV} state_t;

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic          squash_q, squash_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   burst_base_q, burst_base_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fetch_err_q, fetch_err_d;

  logic [31:0]   fifo_insn [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];

  logic          push;
  logic          pop;
  logic          capture;
  logic [31:0]   capture_pc;

  assign mem_addr        = fetch_pc_q;
  assign mem_din         = 32'd0;
  assign mem_access_size = 3'b001;
  assign mem_rw          = 1'b0;
  assign mem_enable      = (state_q == ISSUE);

  assign insn_valid = (count_q != '0);
  assign insn       = insn_valid ? fifo_insn[rd_ptr_q] : 32'd0;
  assign insn_pc    = insn_valid ? fifo_pc[rd_ptr_q]   : 32'd0;
  assign fetch_err  = fetch_err_q;

  assign capture    = (state_q == RECV) && !squash_q;
  assign capture_pc = burst_base_q + {28'd0, beat_q, 2'b00};
  // A redirect in the same edge discards both the push and the pop.
  assign push       = capture && !redirect;
  assign pop        = insn_valid && insn_ready && !redirect;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    squash_d     = squash_q;
    fetch_pc_d   = fetch_pc_q;
    burst_base_d = burst_base_q;
    case (state_q)
      IDLE: begin
        // Holding IDLE on a redirect keeps ISSUE from presenting the stale PC.
        if (!mem_busy && (count_q <= ISSUE_LIMIT) && !redirect) state_d = ISSUE;
      end
      ISSUE: begin
        burst_base_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + 32'd16;
        squash_d     = 1'b0;
        state_d      = WAIT;
      end
      WAIT: begin
        beat_d  = 2'd0;
        state_d = RECV;
      end
      RECV: begin
        beat_d = beat_q + 2'd1;
        // Post-edge occupancy guarantees room for the next full burst.
        if (beat_q == 2'd3) begin
          state_d = (!mem_busy && (count_d <= ISSUE_LIMIT)) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      if (state_q != IDLE) squash_d = 1'b1;
    end
  end

`ifdef MIPS_FETCH_PC_CHECK_EN
  always_comb begin
    fetch_err_d = fetch_err_q;
    if (capture && (mem_pc != capture_pc)) fetch_err_d = 1'b1;
  end
`else
  logic unused_mem_pc;
  assign unused_mem_pc = ^mem_pc;
  always_comb begin
    fetch_err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      squash_q     <= 1'b0;
      fetch_pc_q   <= START_ADDR;
      burst_base_q <= START_ADDR;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      squash_q     <= squash_d;
      fetch_pc_q   <= fetch_pc_d;
      burst_base_q <= burst_base_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_insn[wr_ptr_q] <= mem_dout;
      fifo_pc[wr_ptr_q]   <= capture_pc;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a small burst-memory model whose word at A is (A-0x80020000)/4+1.
module tb_mips_fetch_unit;

  localparam logic [31:0] START = 32'h8002_0000;

`ifdef MIPS_FETCH_PC_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [2:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy;
  logic [31:0] mem_dout;
  logic [31:0] mem_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int tests  = 0;
  int failed = 0;

  logic [2:0]  phase = 3'd0;
  logic [31:0] mbase = 32'd0;
  logic [31:0] maddr;
  logic        pc_fault = 1'b0;

  mips_fetch_unit #(.START_ADDR(START), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy),
    .mem_dout(mem_dout), .mem_pc(mem_pc),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ((a - START) >> 2) + 32'd1;
  endfunction

  // Memory: enable sampled at T0, word k presented in the cycle after T(k+1).
  always @(posedge clk) begin
    if (mem_enable) begin
      mbase <= mem_addr;
      phase <= 3'd1;
    end else if (phase == 3'd5) begin
      phase <= 3'd0;
    end else if (phase != 3'd0) begin
      phase <= phase + 3'd1;
    end
  end

  assign maddr    = mbase + {27'd0, phase - 3'd2, 2'b00};
  assign mem_dout = (phase >= 3'd2) ? word_at(maddr) : 32'hDEAD_BEEF;
  assign mem_pc   = maddr + ((pc_fault && phase == 3'd4) ? 32'd4 : 32'd0);

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of cycle 1 after reset release.
  task automatic do_reset(input logic ready);
    rst_n      = 1'b0;
    redirect   = 1'b0;
    insn_ready = ready;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    int n_en;
    int got;
    int en2;
    rst_n       = 1'b1;
    mem_busy    = 1'b0;
    insn_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    #2 rst_n = 1'b0;
    @(negedge clk);

    // Reset state
    check_b("rst_en", mem_enable, 1'b0);
    check_b("rst_valid", insn_valid, 1'b0);
    check_w("rst_insn", insn, 32'd0);
    check_w("rst_insn_pc", insn_pc, 32'd0);
    check_b("rst_err", fetch_err, 1'b0);
    check_w("rst_addr", mem_addr, START);
    check_w("rst_size", {29'd0, mem_access_size}, 32'd1);
    check_b("rst_rw", mem_rw, 1'b0);
    check_w("rst_din", mem_din, 32'd0);

    // Streaming with insn_ready=1
    do_reset(1'b1);
    check_b("a_c1_en", mem_enable, 1'b0);
    tick;
    check_b("a_c2_en", mem_enable, 1'b1);
    check_w("a_c2_addr", mem_addr, START);
    tick;
    tick;
    check_b("a_c4_valid", insn_valid, 1'b0);
    tick;
    check_b("a_c5_valid", insn_valid, 1'b1);
    got = 0;
    en2 = 0;
    for (int c = 5; c < 40; c++) begin
      if (mem_enable && en2 == 0) en2 = c;
      if (insn_valid && insn_ready && got < 8) begin
        check_w("a_insn", insn, 32'(got + 1));
        check_w("a_pc", insn_pc, START + 32'(4 * got));
        got++;
      end
      tick;
    end
    check_w("a_got", 32'(got), 32'd8);
    check_w("a_en2_cycle", 32'(en2), 32'd8);

    // Back-pressure: exactly two bursts fill the FIFO
    do_reset(1'b0);
    n_en = 0;
    for (int c = 1; c <= 30; c++) begin
      if (mem_enable) n_en++;
      tick;
    end
    check_w("b_bursts", 32'(n_en), 32'd2);
    check_b("b_valid", insn_valid, 1'b1);
    check_w("b_head", insn, 32'd1);
    insn_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_w("b_pop_insn", insn, 32'(k + 1));
      check_b("b_no_issue", mem_enable, 1'b0);
      tick;
    end
    check_b("b_count4_idle", mem_enable, 1'b0);
    check_w("b_head5", insn, 32'd5);
    insn_ready = 1'b0;
    tick;
    check_b("b_third_en", mem_enable, 1'b1);
    check_w("b_third_addr", mem_addr, START + 32'h20);
    for (int k = 0; k < 5; k++) tick;
    insn_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_b("b_drain_valid", insn_valid, 1'b1);
      check_w("b_drain_insn", insn, 32'(k + 5));
      check_w("b_drain_pc", insn_pc, START + 32'h10 + 32'(4 * k));
      tick;
    end

    // Redirect in RECV beat 1
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) tick;
    check_b("c_pre_valid", insn_valid, 1'b1);
    check_w("c_pre_insn", insn, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0042;
    tick;
    redirect = 1'b0;
    check_b("c_c6_valid", insn_valid, 1'b0);
    tick;
    check_b("c_c7_valid", insn_valid, 1'b0);
    check_b("c_c7_en", mem_enable, 1'b0);
    tick;
    check_b("c_c8_en", mem_enable, 1'b1);
    check_w("c_c8_addr", mem_addr, 32'h8002_0040);
    tick;
    tick;
    check_b("c_c10_valid", insn_valid, 1'b0);
    tick;
    check_b("c_c11_valid", insn_valid, 1'b1);
    check_w("c_c11_pc", insn_pc, 32'h8002_0040);
    check_w("c_c11_insn", insn, 32'h11);

    // Redirect coincident with ISSUE and a pop
    do_reset(1'b0);
    for (int k = 0; k < 7; k++) tick;
    check_b("d_c8_en", mem_enable, 1'b1);
    check_w("d_c8_addr", mem_addr, START + 32'h10);
    check_b("d_c8_valid", insn_valid, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h8002_1000;
    insn_ready  = 1'b1;
    tick;
    redirect = 1'b0;
    for (int c = 9; c < 14; c++) begin
      check_b("d_squash_valid", insn_valid, 1'b0);
      check_b("d_squash_en", mem_enable, 1'b0);
      tick;
    end
    check_b("d_c14_en", mem_enable, 1'b1);
    check_w("d_c14_addr", mem_addr, 32'h8002_1000);
    tick;
    tick;
    tick;
    check_b("d_c17_valid", insn_valid, 1'b1);
    check_w("d_c17_pc", insn_pc, 32'h8002_1000);
    check_w("d_c17_insn", insn, 32'h401);

    // Reset mid-RECV with memory busy
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) tick;
    mem_busy = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_b("e_rst_valid", insn_valid, 1'b0);
    check_b("e_rst_en", mem_enable, 1'b0);
    check_w("e_rst_insn", insn, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check_b("e_busy_no_en", mem_enable, 1'b0);
      tick;
    end
    mem_busy = 1'b0;
    tick;
    check_b("e_en", mem_enable, 1'b1);
    check_w("e_addr", mem_addr, START);
    tick;
    tick;
    tick;
    check_b("e_valid", insn_valid, 1'b1);
    check_w("e_pc", insn_pc, START);
    check_w("e_insn", insn, 32'd1);

    // mem_pc off by 4 on beat 2
    do_reset(1'b1);
    pc_fault = 1'b1;
    for (int k = 0; k < 5; k++) tick;
    check_b("f_err_before", fetch_err, 1'b0);
    tick;
    check_b("f_err_rise", fetch_err, EXP_ERR);
    check_w("f_head_insn", insn, 32'd3);
    pc_fault = 1'b0;
    for (int k = 0; k < 8; k++) tick;
    check_b("f_err_sticky", fetch_err, EXP_ERR);
    do_reset(1'b0);
    check_b("f_err_cleared", fetch_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
